// File: rtl/rename_alloc_ctrl.sv
// rtl/rename_alloc_ctrl.sv - physical register free-bitmap allocator with flush recovery
//
// Owns the free bitmap of the physical register file (1 = free). Serves an
// all-or-nothing NUM_REQUESTS-wide dispatch group, takes retire frees, and
// restores squashed registers on flush followed by a short dispatch block.
//
// Ports:
//   clock, reset      clock; asynchronous active-low reset
//   disp_valid        per-slot allocation request
//   disp_ready        whole group accepted this cycle (from registered state)
//   alloc_valid/idx   registered per-slot grant, valid one cycle after fire
//   free_valid/idx    per-slot register release from retire
//   flush/flush_mask  squash pulse and registers returned to the pool
//   free_count        registered popcount of the free bitmap
//   dbl_free_err      sticky flag: freed a register that was already free
module rename_alloc_ctrl #(
  parameter int NUM_RESOURCES  = 64,
  parameter int NUM_REQUESTS   = 3,
  parameter int NUM_ARCH       = 32,
  parameter int RECOVER_CYCLES = 2,
  localparam int IDX_W = $clog2(NUM_RESOURCES),
  localparam int CNT_W = $clog2(NUM_RESOURCES + 1)
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_REQUESTS-1:0]         disp_valid,
  output logic                            disp_ready,
  output logic [NUM_REQUESTS-1:0]         alloc_valid,
  output logic [NUM_REQUESTS*IDX_W-1:0]   alloc_idx,
  input  logic [NUM_REQUESTS-1:0]         free_valid,
  input  logic [NUM_REQUESTS*IDX_W-1:0]   free_idx,
  input  logic                            flush,
  input  logic [NUM_RESOURCES-1:0]        flush_mask,
  output logic [CNT_W-1:0]                free_count,
  output logic                            dbl_free_err
);

  localparam int RC_W = $clog2(RECOVER_CYCLES + 1);

  typedef enum logic {RUN, RECOVER} state_t;

  state_t                   state;
  logic [RC_W-1:0]          rec_cnt;
  logic [NUM_RESOURCES-1:0] fb;

  logic [CNT_W-1:0]         req_cnt;
  logic                     fire;
  logic [NUM_RESOURCES-1:0] avail;
  logic [NUM_RESOURCES-1:0] alloc_bits;
  logic [IDX_W-1:0]         sel_idx [NUM_REQUESTS];
  logic                     found;
  logic [NUM_RESOURCES-1:0] free_bits;
  logic                     dbl;
  logic [NUM_RESOURCES-1:0] fb_next;
  logic [CNT_W-1:0]         next_count;

  always_comb begin
    req_cnt = '0;
    for (int i = 0; i < NUM_REQUESTS; i++) begin
      req_cnt = req_cnt + CNT_W'(disp_valid[i]);
    end
  end

  // Ready looks only at registered free_count, so same-cycle frees never help.
  assign disp_ready = reset && (state == RUN) && !flush && (free_count >= req_cnt);
  assign fire       = disp_ready && (|disp_valid);

  // Each requesting slot, in ascending order, takes the lowest free register
  // not already claimed by an earlier slot.
  always_comb begin
    avail      = fb;
    alloc_bits = '0;
    found      = 1'b0;
    for (int s = 0; s < NUM_REQUESTS; s++) begin
      sel_idx[s] = '0;
      found      = 1'b0;
      if (disp_valid[s]) begin
        for (int r = 0; r < NUM_RESOURCES; r++) begin
          if (!found && avail[r]) begin
            sel_idx[s]    = IDX_W'(r);
            avail[r]      = 1'b0;
            alloc_bits[r] = 1'b1;
            found         = 1'b1;
          end
        end
      end
    end
  end

  // A free hitting a bit that is already free, or freed by an earlier slot
  // this same cycle, is a double free.
  always_comb begin
    free_bits = '0;
    dbl       = 1'b0;
    for (int i = 0; i < NUM_REQUESTS; i++) begin
      if (free_valid[i]) begin
        if (fb[free_idx[i*IDX_W +: IDX_W]] || free_bits[free_idx[i*IDX_W +: IDX_W]]) begin
          dbl = 1'b1;
        end
        free_bits[free_idx[i*IDX_W +: IDX_W]] = 1'b1;
      end
    end
  end

  always_comb begin
    fb_next = (fb | free_bits | (flush ? flush_mask : '0)) & ~(fire ? alloc_bits : '0);
    next_count = '0;
    for (int r = 0; r < NUM_RESOURCES; r++) begin
      next_count = next_count + CNT_W'(fb_next[r]);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fb           <= {{(NUM_RESOURCES-NUM_ARCH){1'b1}}, {NUM_ARCH{1'b0}}};
      state        <= RUN;
      rec_cnt      <= '0;
      free_count   <= CNT_W'(NUM_RESOURCES - NUM_ARCH);
      alloc_valid  <= '0;
      alloc_idx    <= '0;
      dbl_free_err <= 1'b0;
    end else begin
      fb           <= fb_next;
      free_count   <= next_count;
      alloc_valid  <= fire ? disp_valid : '0;
      dbl_free_err <= dbl_free_err | dbl;
      for (int s = 0; s < NUM_REQUESTS; s++) begin
        alloc_idx[s*IDX_W +: IDX_W] <= (fire && disp_valid[s]) ? sel_idx[s] : '0;
      end
      if (flush) begin
        state   <= RECOVER;
        rec_cnt <= RC_W'(RECOVER_CYCLES);
      end else if (state == RECOVER) begin
        // Leaving on a count of 1 gives exactly RECOVER_CYCLES blocked cycles.
        if (rec_cnt <= RC_W'(1)) begin
          state <= RUN;
        end else begin
          rec_cnt <= rec_cnt - RC_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_rename_alloc_ctrl.sv
// tb/tb_rename_alloc_ctrl.sv - randomized self-checking bench for rename_alloc_ctrl
module tb_rename_alloc_ctrl;

  localparam int NR   = 64;
  localparam int NQ   = 3;
  localparam int NA   = 32;
  localparam int RC   = 2;
  localparam int IW   = 6;
  localparam int CW   = 7;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [NQ-1:0]   disp_valid = '0;
  logic            disp_ready;
  logic [NQ-1:0]   alloc_valid;
  logic [NQ*IW-1:0] alloc_idx;
  logic [NQ-1:0]   free_valid = '0;
  logic [NQ*IW-1:0] free_idx = '0;
  logic            flush = 1'b0;
  logic [NR-1:0]   flush_mask = '0;
  logic [CW-1:0]   free_count;
  logic            dbl_free_err;

  int checks = 0;
  int passes = 0;

  bit mfb [NR];
  bit merr;
  int mrec;

  logic          exp_ready;
  logic [NQ-1:0] exp_av;
  int            exp_idx [NQ];
  int            exp_count;
  logic          exp_err;

  rename_alloc_ctrl #(
    .NUM_RESOURCES(NR), .NUM_REQUESTS(NQ), .NUM_ARCH(NA), .RECOVER_CYCLES(RC)
  ) dut (
    .clock(clock), .reset(reset), .disp_valid(disp_valid), .disp_ready(disp_ready),
    .alloc_valid(alloc_valid), .alloc_idx(alloc_idx), .free_valid(free_valid),
    .free_idx(free_idx), .flush(flush), .flush_mask(flush_mask),
    .free_count(free_count), .dbl_free_err(dbl_free_err)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int mpop();
    int n = 0;
    for (int r = 0; r < NR; r++) n += int'(mfb[r]);
    return n;
  endfunction

  function automatic void model_reset();
    for (int r = 0; r < NR; r++) mfb[r] = (r >= NA);
    merr = 0;
    mrec = 0;
  endfunction

  task automatic clear_inputs();
    disp_valid = '0; free_valid = '0; free_idx = '0; flush = 1'b0; flush_mask = '0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    clear_inputs();
    model_reset();
    @(negedge clock);
    reset = 1'b1;
  endtask

  // Applies one cycle of inputs at the falling edge and advances the model.
  task automatic drive(input logic [NQ-1:0] dv, input logic [NQ-1:0] fv,
                       input int f0, input int f1, input int f2,
                       input logic fl, input logic [NR-1:0] fm);
    int fi [NQ];
    int freeq [$];
    bit nfb [NR];
    int pop;
    int k;
    bit fire;
    fi[0] = f0; fi[1] = f1; fi[2] = f2;
    @(negedge clock);
    disp_valid = dv;
    free_valid = fv;
    free_idx   = {IW'(f2), IW'(f1), IW'(f0)};
    flush      = fl;
    flush_mask = fm;
    #1;
    pop = int'(dv[0]) + int'(dv[1]) + int'(dv[2]);
    exp_ready = (mrec == 0) && !fl && (mpop() >= pop);
    fire = exp_ready && (dv != 0);
    for (int r = 0; r < NR; r++) if (mfb[r]) freeq.push_back(r);
    k = 0;
    for (int s = 0; s < NQ; s++) begin
      exp_idx[s] = 0;
      if (fire && dv[s]) begin
        exp_idx[s] = freeq[k];
        k++;
      end
    end
    exp_av = fire ? dv : '0;
    nfb = mfb;
    for (int i = 0; i < NQ; i++) begin
      if (fv[i]) begin
        if (nfb[fi[i]]) merr = 1;
        nfb[fi[i]] = 1;
      end
    end
    if (fl) for (int r = 0; r < NR; r++) if (fm[r]) nfb[r] = 1;
    if (fire) for (int s = 0; s < NQ; s++) if (dv[s]) nfb[exp_idx[s]] = 0;
    if (fl) mrec = RC;
    else if (mrec > 0) mrec--;
    mfb = nfb;
    exp_count = mpop();
    exp_err = merr;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    #3;
    reset = 1'b0;
    #1;
    checks++; if (disp_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", disp_ready); else passes++;
    checks++; if (alloc_valid !== 3'b000) $display("FAIL reset_av: got %b want 000", alloc_valid); else passes++;
    checks++; if (alloc_idx !== '0) $display("FAIL reset_idx: got %h want 0", alloc_idx); else passes++;
    checks++; if (free_count !== CW'(NR-NA)) $display("FAIL reset_count: got %0d want %0d", free_count, NR-NA); else passes++;
    checks++; if (dbl_free_err !== 1'b0) $display("FAIL reset_err: got %b want 0", dbl_free_err); else passes++;
    model_reset();
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_full_group();
    do_reset();
    drive(3'b111, 3'b000, 0, 0, 0, 1'b0, '0);
    checks++; if (disp_ready !== 1'b1) $display("FAIL full_ready: got %b want 1", disp_ready); else passes++;
    tick();
    checks++; if (alloc_valid !== 3'b111) $display("FAIL full_av: got %b want 111", alloc_valid); else passes++;
    checks++; if (alloc_idx[0 +: IW] !== IW'(32)) $display("FAIL full_idx0: got %0d want 32", alloc_idx[0 +: IW]); else passes++;
    checks++; if (alloc_idx[IW +: IW] !== IW'(33)) $display("FAIL full_idx1: got %0d want 33", alloc_idx[IW +: IW]); else passes++;
    checks++; if (alloc_idx[2*IW +: IW] !== IW'(34)) $display("FAIL full_idx2: got %0d want 34", alloc_idx[2*IW +: IW]); else passes++;
    checks++; if (free_count !== CW'(29)) $display("FAIL full_count: got %0d want 29", free_count); else passes++;
    clear_inputs();
    tick();
    checks++; if (alloc_valid !== 3'b000) $display("FAIL full_av_drop: got %b want 000", alloc_valid); else passes++;
  endtask

  task automatic test_partial();
    do_reset();
    drive(3'b101, 3'b000, 0, 0, 0, 1'b0, '0);
    tick();
    checks++; if (alloc_valid !== exp_av) $display("FAIL part_av: got %b want %b", alloc_valid, exp_av); else passes++;
    checks++; if (alloc_idx !== {IW'(exp_idx[2]), IW'(exp_idx[1]), IW'(exp_idx[0])})
      $display("FAIL part_idx: got %h want %0d/%0d/%0d", alloc_idx, exp_idx[0], exp_idx[1], exp_idx[2]); else passes++;
    checks++; if (alloc_idx !== {IW'(33), IW'(0), IW'(32)}) $display("FAIL part_idx_const: got %h", alloc_idx); else passes++;
    checks++; if (free_count !== CW'(30)) $display("FAIL part_count: got %0d want 30", free_count); else passes++;
  endtask

  task automatic test_exhaust_and_free();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(3'b111, 3'b000, 0, 0, 0, 1'b0, '0);
      tick();
    end
    checks++; if (free_count !== CW'(2)) $display("FAIL exh_count2: got %0d want 2", free_count); else passes++;
    drive(3'b111, 3'b000, 0, 0, 0, 1'b0, '0);
    checks++; if (disp_ready !== 1'b0) $display("FAIL exh_ready: got %b want 0", disp_ready); else passes++;
    tick();
    checks++; if (alloc_valid !== 3'b000 || free_count !== CW'(2))
      $display("FAIL exh_nochange: got av=%b cnt=%0d want av=000 cnt=2", alloc_valid, free_count); else passes++;
    drive(3'b011, 3'b000, 0, 0, 0, 1'b0, '0);
    tick();
    checks++; if (alloc_idx !== {IW'(0), IW'(63), IW'(62)}) $display("FAIL exh_last: got %h want 62/63", alloc_idx); else passes++;
    checks++; if (free_count !== CW'(0)) $display("FAIL exh_count0: got %0d want 0", free_count); else passes++;
    drive(3'b001, 3'b001, 40, 0, 0, 1'b0, '0);
    checks++; if (disp_ready !== 1'b0) $display("FAIL samecyc_ready: got %b want 0", disp_ready); else passes++;
    tick();
    checks++; if (free_count !== CW'(1)) $display("FAIL samecyc_count: got %0d want 1", free_count); else passes++;
    drive(3'b001, 3'b000, 0, 0, 0, 1'b0, '0);
    checks++; if (disp_ready !== 1'b1) $display("FAIL reuse_ready: got %b want 1", disp_ready); else passes++;
    tick();
    checks++; if (alloc_valid !== 3'b001 || alloc_idx[0 +: IW] !== IW'(40))
      $display("FAIL reuse_grant: got av=%b idx=%0d want 001/40", alloc_valid, alloc_idx[0 +: IW]); else passes++;
  endtask

  task automatic test_flush();
    logic [NR-1:0] m;
    do_reset();
    drive(3'b111, 3'b000, 0, 0, 0, 1'b0, '0);
    tick();
    m = '0;
    m[35:32] = 4'hf;
    drive(3'b111, 3'b000, 0, 0, 0, 1'b1, m);
    checks++; if (disp_ready !== 1'b0) $display("FAIL flush_ready_t: got %b want 0", disp_ready); else passes++;
    tick();
    checks++; if (alloc_valid !== 3'b000) $display("FAIL flush_nogrant: got %b want 000", alloc_valid); else passes++;
    checks++; if (free_count !== CW'(32)) $display("FAIL flush_count: got %0d want 32", free_count); else passes++;
    checks++; if (dbl_free_err !== 1'b0) $display("FAIL flush_err: got %b want 0", dbl_free_err); else passes++;
    for (int c = 1; c <= RC; c++) begin
      drive(3'b111, 3'b000, 0, 0, 0, 1'b0, '0);
      checks++; if (disp_ready !== 1'b0) $display("FAIL flush_block%0d: got %b want 0", c, disp_ready); else passes++;
      tick();
    end
    drive(3'b111, 3'b000, 0, 0, 0, 1'b0, '0);
    checks++; if (disp_ready !== 1'b1) $display("FAIL flush_resume: got %b want 1", disp_ready); else passes++;
    tick();
    checks++; if (alloc_idx !== {IW'(34), IW'(33), IW'(32)}) $display("FAIL flush_regrant: got %h want 32/33/34", alloc_idx); else passes++;
  endtask

  task automatic test_double_free_and_async_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(3'b111, 3'b000, 0, 0, 0, 1'b0, '0);
      tick();
    end
    drive(3'b000, 3'b001, 40, 0, 0, 1'b0, '0);
    tick();
    checks++; if (dbl_free_err !== 1'b0 || free_count !== CW'(24))
      $display("FAIL dbl_first: got err=%b cnt=%0d want 0/24", dbl_free_err, free_count); else passes++;
    drive(3'b000, 3'b001, 40, 0, 0, 1'b0, '0);
    tick();
    checks++; if (dbl_free_err !== 1'b1 || free_count !== CW'(24))
      $display("FAIL dbl_second: got err=%b cnt=%0d want 1/24", dbl_free_err, free_count); else passes++;
    drive(3'b000, 3'b110, 0, 50, 50, 1'b0, '0);
    tick();
    checks++; if (dbl_free_err !== exp_err || free_count !== CW'(exp_count))
      $display("FAIL dbl_sticky: got err=%b cnt=%0d want %b/%0d", dbl_free_err, free_count, exp_err, exp_count); else passes++;
    drive(3'b111, 3'b000, 0, 0, 0, 1'b0, '0);
    tick();
    drive(3'b111, 3'b000, 0, 0, 0, 1'b0, '0);
    #1;
    reset = 1'b0;
    #1;
    checks++; if (alloc_valid !== 3'b000 || alloc_idx !== '0)
      $display("FAIL midrst_alloc: got av=%b idx=%h want 0/0", alloc_valid, alloc_idx); else passes++;
    checks++; if (free_count !== CW'(32) || dbl_free_err !== 1'b0 || disp_ready !== 1'b0)
      $display("FAIL midrst_state: got cnt=%0d err=%b rdy=%b want 32/0/0", free_count, dbl_free_err, disp_ready); else passes++;
    clear_inputs();
    model_reset();
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_random();
    int held [$];
    int f [NQ];
    logic [NQ-1:0] dv;
    logic [NQ-1:0] fv;
    logic fl;
    logic [NR-1:0] fm;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      held.delete();
      for (int r = 0; r < NR; r++) if (!mfb[r]) held.push_back(r);
      dv = NQ'($urandom_range(0, 7));
      fv = '0;
      for (int i = 0; i < NQ; i++) begin
        f[i] = 0;
        if ($urandom_range(0, 2) == 0) begin
          fv[i] = 1'b1;
          if (held.size() == 0 || $urandom_range(0, 15) == 0) f[i] = $urandom_range(0, NR-1);
          else f[i] = held[$urandom_range(0, held.size()-1)];
        end
      end
      fl = ($urandom_range(0, 24) == 0);
      fm = fl ? ({$urandom, $urandom} & {$urandom, $urandom}) : '0;
      drive(dv, fv, f[0], f[1], f[2], fl, fm);
      checks++; if (disp_ready !== exp_ready) $display("FAIL rnd_ready[%0d]: got %b want %b", n, disp_ready, exp_ready); else passes++;
      tick();
      checks++; if (alloc_valid !== exp_av) $display("FAIL rnd_av[%0d]: got %b want %b", n, alloc_valid, exp_av); else passes++;
      checks++; if (alloc_idx !== {IW'(exp_idx[2]), IW'(exp_idx[1]), IW'(exp_idx[0])})
        $display("FAIL rnd_idx[%0d]: got %h want %0d/%0d/%0d", n, alloc_idx, exp_idx[0], exp_idx[1], exp_idx[2]); else passes++;
      checks++; if (free_count !== CW'(exp_count)) $display("FAIL rnd_count[%0d]: got %0d want %0d", n, free_count, exp_count); else passes++;
      checks++; if (dbl_free_err !== exp_err) $display("FAIL rnd_err[%0d]: got %b want %b", n, dbl_free_err, exp_err); else passes++;
    end
    clear_inputs();
  endtask

  initial begin
    model_reset();
    #12;
    reset = 1'b1;
    test_reset();
    test_full_group();
    test_partial();
    test_exhaust_and_free();
    test_flush();
    test_double_free_and_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
